// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 active-low keypad row scanner with press/release debounce
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
// Revision: 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 1024
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       keystrobe,
  output logic [3:0] keycode,
  output logic       pressed
);

  localparam int                 c_DIV_W    = $clog2(SCAN_DIV);
  localparam int                 c_DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
  localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0]  c_DB_ONE   = c_DB_W'(1);
  localparam logic [3:0]         c_IDLE     = 4'hF;

  if (SCAN_DIV < 4) begin : g_chk_scan_div
    $error("SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_chk_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_STROBE   = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  state_t             r_state;
  logic [3:0]         r_col_meta;
  logic [3:0]         r_col_sync;
  logic [1:0]         r_row_idx;
  logic [3:0]         r_row;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic [3:0]         r_pattern;
  logic               r_keystrobe;
  logic [3:0]         r_keycode;
  logic               r_pressed;
  logic [1:0]         w_col_idx;
  logic               w_idle;
  logic               w_match;

`ifdef KEYPAD_REPEAT_EN
  localparam int                 c_REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);
  localparam logic [c_REP_W-1:0] c_REP_ONE  = c_REP_W'(1);
  logic [c_REP_W-1:0] r_rep_cnt;
`endif

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign w_idle  = (r_col_sync == c_IDLE);
  assign w_match = (r_col_sync == r_pattern);

  // Several keys on one row: the lowest column index wins.
  always_comb begin
    w_col_idx = 2'd3;
    if (!r_pattern[0])      w_col_idx = 2'd0;
    else if (!r_pattern[1]) w_col_idx = 2'd1;
    else if (!r_pattern[2]) w_col_idx = 2'd2;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_SCAN;
      r_col_meta  <= c_IDLE;
      r_col_sync  <= c_IDLE;
      r_row_idx   <= 2'd0;
      r_row       <= 4'b1110;
      r_div_cnt   <= '0;
      r_db_cnt    <= '0;
      r_pattern   <= c_IDLE;
      r_keystrobe <= 1'b0;
      r_keycode   <= 4'h0;
      r_pressed   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
`endif
    end else begin
      r_col_meta  <= col;
      r_col_sync  <= r_col_meta;
      r_keystrobe <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            if (w_idle) begin
              r_row_idx <= r_row_idx + 2'd1;
              r_row     <= row_drive(r_row_idx + 2'd1);
            end else begin
              r_pattern <= r_col_sync;
              r_db_cnt  <= '0;
              r_state   <= ST_DEBOUNCE;
            end
          end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_idle || !w_match) begin
            r_div_cnt <= '0;
            r_state   <= ST_SCAN;
          end else if (r_db_cnt == c_DB_LAST) begin
            r_keystrobe <= 1'b1;
            r_keycode   <= {r_row_idx, w_col_idx};
            r_pressed   <= 1'b1;
            r_state     <= ST_STROBE;
          end else begin
            r_db_cnt <= r_db_cnt + c_DB_ONE;
          end
        end
        ST_STROBE: begin
          r_db_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
          r_rep_cnt <= '0;
`endif
          r_state  <= ST_HOLD;
        end
        default: begin
          // Release needs an unbroken run of idle samples; any bounce restarts it.
          if (w_idle) begin
            if (r_db_cnt == c_DB_LAST) begin
              r_pressed <= 1'b0;
              r_div_cnt <= '0;
              r_row_idx <= r_row_idx + 2'd1;
              r_row     <= row_drive(r_row_idx + 2'd1);
              r_state   <= ST_SCAN;
            end else begin
              r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= '0;
`endif
          end else begin
            r_db_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
            if (!w_match) begin
              r_rep_cnt <= '0;
            end else if (r_rep_cnt == c_REP_LAST) begin
              r_rep_cnt   <= '0;
              r_keystrobe <= 1'b1;
              r_state     <= ST_STROBE;
            end else begin
              r_rep_cnt <= r_rep_cnt + c_REP_ONE;
            end
`endif
          end
        end
      endcase
    end
  end

  assign row       = r_row;
  assign keystrobe = r_keystrobe;
  assign keycode   = r_keycode;
  assign pressed   = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed stimulus with a keycode scoreboard for keypad_scanner
// Revision: 1.0
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 3;
  localparam int REPEAT_CYCLES   = 20;

  logic       clk  = 1'b0;
  logic       nrst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic       keystrobe;
  logic [3:0] keycode;
  logic       pressed;

  // Keypad model: the key pulls its pattern low only while its row is driven.
  logic [1:0] key_row   = 2'd0;
  logic [3:0] key_pat   = 4'hF;
  logic       force_en  = 1'b0;
  logic [3:0] force_col = 4'hF;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  assign col = force_en ? force_col :
               ((row == ~(4'b0001 << key_row)) ? key_pat : 4'hF);

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .col       (col),
    .row       (row),
    .keystrobe (keystrobe),
    .keycode   (keycode),
    .pressed   (pressed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe.
  logic       prev_strobe  = 1'b0;
  logic [3:0] prev_keycode = 4'h0;
  always @(negedge clk) begin
    if (nrst) begin
      if (keystrobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe with keycode %0h expected none", keycode);
        end else begin
          check("strobe_keycode", keycode, exp_q.pop_front());
          check("strobe_pressed", pressed, 1);
        end
        check("strobe_not_back_to_back", prev_strobe, 0);
      end else if (keycode != prev_keycode) begin
        check("keycode_change_without_strobe", keycode, prev_keycode);
      end
    end
    prev_strobe  = keystrobe;
    prev_keycode = keycode;
  end

  task automatic wait_pressed(input logic val, input string name);
    int n = 0;
    while (pressed !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, pressed, val);
  endtask

  // Called on the negedge where col goes steadily idle.
  task automatic check_release(input logic [3:0] exp_row, input string name);
    repeat (4) @(negedge clk);
    check({name, "_held_until_debounced"}, pressed, 1);
    @(negedge clk);
    check({name, "_released"}, pressed, 0);
    check({name, "_next_row"}, row, exp_row);
  endtask

  // Called on the negedge where nrst is released.
  task automatic check_scan_sequence(input int cycles, input string name);
    for (int k = 1; k <= cycles; k++) begin
      logic [1:0] idx;
      logic [3:0] er;
      idx = 2'((k / SCAN_DIV) % 4);
      er  = ~(4'b0001 << idx);
      @(negedge clk);
      check(name, row, er);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_row", row, 4'b1110);
    check("reset_keycode", keycode, 0);
    check("reset_keystrobe", keystrobe, 0);
    check("reset_pressed", pressed, 0);
    nrst = 1'b1;

    // Idle scan
    check_scan_sequence(40, "idle_scan_row");
    check("idle_keycode", keycode, 0);

    // Row 1, column 2 held
    exp_q.push_back(4'h6);
    key_row = 2'd1;
    key_pat = 4'b1011;
    wait_pressed(1'b1, "row1_accept");
    repeat (60) @(negedge clk);
    check("row1_still_pressed", pressed, 1);
    key_pat = 4'hF;
    check_release(4'b1011, "row1");

    // Two-cycle glitch timed to hit the row 0 evaluation
    n = 0;
    while (row !== 4'b1110 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("glitch_row0_reached", row, 4'b1110);
    @(negedge clk);
    force_col = 4'b1110;
    force_en  = 1'b1;
    repeat (2) @(negedge clk);
    force_col = 4'hF;
    repeat (2) @(negedge clk);
    check("glitch_debounce_not_pressed", pressed, 0);
    repeat (4) @(negedge clk);
    check("glitch_row_kept", row, 4'b1110);
    @(negedge clk);
    check("glitch_row_advanced", row, 4'b1101);
    check("glitch_keycode_kept", keycode, 4'h6);
    force_en = 1'b0;

    // Row 3, two columns low
    exp_q.push_back(4'hC);
    key_row = 2'd3;
    key_pat = 4'b1100;
    wait_pressed(1'b1, "row3_accept");
    repeat (10) @(negedge clk);
    key_pat = 4'hF;
    check_release(4'b1110, "row3");

    // Row 2 with a bouncy release
    exp_q.push_back(4'hB);
    key_row = 2'd2;
    key_pat = 4'b0111;
    wait_pressed(1'b1, "row2_accept");
    repeat (5) @(negedge clk);
    force_col = 4'b0111;
    force_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      force_col = (i % 2 == 0) ? 4'hF : 4'b0111;
      @(negedge clk);
      check("bounce_still_pressed", pressed, 1);
    end
    force_col = 4'hF;
    check_release(4'b0111, "row2_bounce");
    key_pat  = 4'hF;
    force_en = 1'b0;

    // Asynchronous reset while holding a key
    exp_q.push_back(4'h6);
    key_row = 2'd1;
    key_pat = 4'b1011;
    wait_pressed(1'b1, "hold_reset_accept");
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("async_reset_row", row, 4'b1110);
    check("async_reset_pressed", pressed, 0);
    check("async_reset_keystrobe", keystrobe, 0);
    check("async_reset_keycode", keycode, 0);
    key_pat = 4'hF;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    check_scan_sequence(8, "post_reset_scan_row");

    repeat (5) @(negedge clk);
    check("all_strobes_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 16: clk cycles each row is driven before its columns are evaluated (min 4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive identical synchronized column samples required to accept a press or a release (min 2).
REQ-003 Parameter REPEAT_CYCLES, default 1024: hold time between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 col  input  4  keypad column sense, active-low (pull-ups external), asynchronous to clk.
REQ-007 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 keystrobe  output  1  one-cycle pulse marking a newly accepted key.
REQ-009 keycode  output  4  accepted key = {row_idx[1:0], col_idx[1:0]}; stable between strobes.
REQ-010 pressed  output  1  high while a debounced key is held (STROBE and HOLD states).

Function
REQ-011 col SHALL pass through a 2-flop synchronizer (reset value 4'hF) before any use; raw col never reaches logic.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, STROBE, HOLD.
REQ-013 SCAN: row held for SCAN_DIV cycles; on the last cycle, if synchronized col == 4'hF, advance row_idx 0->1->2->3->0 (wrap) and restart the dwell counter.
REQ-014 SCAN: if synchronized col != 4'hF on the last dwell cycle, capture the pattern, freeze row, go to DEBOUNCE.
REQ-015 DEBOUNCE: any sample differing from the captured pattern, or equal to 4'hF, SHALL return to SCAN with the same row and a restarted dwell counter, with no strobe.
REQ-016 DEBOUNCE: after DEBOUNCE_CYCLES consecutive matching samples, go to STROBE.
REQ-017 STROBE: keystrobe=1 for exactly that cycle; keycode updates in the same cycle; next state HOLD unconditionally.
REQ-018 Multiple low columns: col_idx SHALL be the lowest-index low bit of the captured pattern.
REQ-019 HOLD: row stays frozen; after DEBOUNCE_CYCLES consecutive samples equal to 4'hF, go to SCAN with row advanced to the next index; shorter releases SHALL be ignored.
REQ-020 keystrobe SHALL never be high in two consecutive cycles.
REQ-021 keycode SHALL change only in STROBE; pressed SHALL be 0 in SCAN and DEBOUNCE.

Reset
REQ-022 While nrst=0: state SCAN, row=4'b1110 (row_idx 0), keycode=4'h0, keystrobe=0, pressed=0, all counters 0, synchronizer flops 4'hF.
REQ-023 Reset asserted mid-DEBOUNCE, STROBE or HOLD SHALL abort immediately with no strobe generated; scanning resumes from row 0 on the first edge after release.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in HOLD, when the key stays pressed (pattern unchanged) for REPEAT_CYCLES cycles, go to STROBE again with the same keycode, then back to HOLD with the repeat counter cleared.
REQ-025 KEYPAD_REPEAT_EN undefined: no repeat counter is built; a held key yields exactly one strobe; REPEAT_CYCLES is unused.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=3, REPEAT_CYCLES=20)
REQ-026 Reset then idle col=4'hF for 40 cycles -> row cycles 1110,1101,1011,0111,1110 every 4 cycles; keystrobe never 1; keycode=0.
REQ-027 col=4'b1011 asserted only while row=4'b1101, held 60 cycles -> exactly one keystrobe with keycode=4'h6; pressed=1 until release debounced; repeat build adds a strobe every 21 cycles of hold.
REQ-028 col low for 2 cycles only (glitch) during row 0 evaluation -> return to SCAN, no keystrobe, keycode unchanged.
REQ-029 col=4'b1100 held during row 3 -> keycode=4'hC (lowest column wins), one strobe.
REQ-030 Release bounce: after strobe on row 2, col toggles 1-cycle high pulses for 10 cycles then steady 4'hF -> no second strobe; SCAN resumes at row 3 after 3 clean high samples.
REQ-031 nrst pulsed low while in HOLD -> all outputs at reset values asynchronously; no strobe on release; scan restarts at row=4'b1110.
